// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   // Arbiter top-level states: zero-fill sweep, then normal service
   typedef enum logic {
      INIT  = 1'b0,
      SERVE = 1'b1
   } state_t;

   // Requester identifiers, also used as bit indices into req/gnt vectors
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Default geometry: 1024 x 32 single-port memory
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not granted
// last wins; a lone request is granted directly. Purely combinational.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   // One-hot (or zero) grant from the current requests and last winner
   always_comb begin
      gnt = '0;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M1) ? 2'b01 : 2'b10;
            default: gnt = '0;
         endcase
      end
   end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU
// load/store port (m0) and the debug/loader port (m1). Clears the memory
// after reset, then serves requests with round-robin arbitration and a
// one-cycle registered read return.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int INIT_CLEAR = 1
)(
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              init_done
);

   localparam state_t RST_STATE = (INIT_CLEAR != 0) ? INIT : SERVE;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic              last_gnt;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              arb_en;
   logic              sweeping;

   assign req      = {m1_req, m0_req};
   // Gating with rst keeps the memory and requesters quiet while reset is held
   assign arb_en   = rst && (state == SERVE);
   assign sweeping = rst && (state == INIT);

   rr_arb2 u_arb (
      .req  (req),
      .last (last_gnt),
      .en   (arb_en),
      .gnt  (gnt)
   );

   assign m0_gnt = gnt[M0];
   assign m1_gnt = gnt[M1];

   // Memory port mux: sweep writes, winner's access, or hold the address
   always_comb begin
      mem_addr  = addr_hold;
      mem_wdata = '0;
      mem_wr    = 1'b0;
      if (sweeping) begin
         mem_addr = clr_cnt;
         mem_wr   = 1'b1;
      end else if (gnt[M0]) begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_wr    = m0_we;
      end else if (gnt[M1]) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_wr    = m1_we;
      end
   end

   // Control FSM: zero-fill sweep of every word, then serve requests
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RST_STATE;
         clr_cnt   <= '0;
         init_done <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == '1) begin
                  state     <= SERVE;
                  init_done <= 1'b1;
               end
            end
            SERVE: begin
               init_done <= 1'b1;
            end
            default: begin
               state <= RST_STATE;
            end
         endcase
      end
   end

   // Remember the last driven address so an idle cycle does not move it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_hold <= '0;
      end else begin
         addr_hold <= mem_addr;
      end
   end

   // Round-robin history: record the winner on every grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt <= M1;
      end else if (|gnt) begin
         last_gnt <= gnt[M1] ? M1 : M0;
      end
   end

   // Read return: capture memory data at the end of a read grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rvalid <= 1'b0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= gnt[M0] && !m0_we;
         m1_rvalid <= gnt[M1] && !m1_we;
         if (gnt[M0] && !m0_we) begin
            m0_rdata <= mem_rdata;
         end
         if (gnt[M1] && !m1_we) begin
            m1_rdata <= mem_rdata;
         end
      end
   end

   // Grant sanity: at most one winner, and only for an active request
   always_ff @(posedge clk) begin
      if (rst) begin
         assert ($onehot0(gnt)) else $error("grant not one-hot: %b", gnt);
         assert ((gnt & ~req) == 2'b00) else $error("grant without request: %b", gnt);
      end
   end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory. Stimulus pushes
// expected read data into per-requester queues; a monitor pops on rvalid.
module tb_dmem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          m0_req = 1'b0, m0_we = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m0_gnt, m0_rvalid;
   logic [DW-1:0] m0_rdata;
   logic          m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m1_gnt, m1_rvalid;
   logic [DW-1:0] m1_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          init_done;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit            erv0 = 1'b0, erv1 = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .init_done(init_done)
   );

   // Behavioural single-port memory: synchronous write, combinational read
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every rvalid pulse must match the oldest expected read
   always @(negedge clk) begin
      if (rst) begin
         if (m0_rvalid) begin
            if (q0.size() == 0) check("m0_rvalid_unexpected", 32'd1, 32'd0);
            else                check("m0_rdata", m0_rdata, q0.pop_front());
         end
         if (m1_rvalid) begin
            if (q1.size() == 0) check("m1_rvalid_unexpected", 32'd1, 32'd0);
            else                check("m1_rdata", m1_rdata, q1.pop_front());
         end
      end
   end

   // One SERVE cycle: drive requests, check grants/memory port/rvalid timing
   task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit eg0, input bit eg1, input logic [DW-1:0] ex);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      @(negedge clk);
      check("m0_gnt", 32'(m0_gnt), 32'(eg0));
      check("m1_gnt", 32'(m1_gnt), 32'(eg1));
      check("m0_rvalid_timing", 32'(m0_rvalid), 32'(erv0));
      check("m1_rvalid_timing", 32'(m1_rvalid), 32'(erv1));
      if (eg0) begin
         check("mem_addr_m0", 32'(mem_addr), 32'(a0));
         check("mem_wr_m0", 32'(mem_wr), 32'(w0));
         if (!w0) q0.push_back(ex);
      end else if (eg1) begin
         check("mem_addr_m1", 32'(mem_addr), 32'(a1));
         check("mem_wr_m1", 32'(mem_wr), 32'(w1));
         if (!w1) q1.push_back(ex);
      end else begin
         check("mem_wr_idle", 32'(mem_wr), 32'd0);
      end
      erv0 = eg0 && !w0;
      erv1 = eg1 && !w1;
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   // Sweep: n cycles of zero writes at ascending addresses, no grants
   task automatic sweep(input int n);
      int errs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (mem_addr !== AW'(i) || mem_wr !== 1'b1 || mem_wdata !== '0 ||
             m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || init_done !== 1'b0 ||
             m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0)
            errs++;
         @(posedge clk); #1;
      end
      check("sweep_cycles_bad", 32'(errs), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #12;
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);

      // Requests held through the sweep must wait for init_done
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h3FF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h3FE;
      @(posedge clk); #1;
      rst = 1'b1;
      sweep(1024);
      check("init_done_after_sweep", 32'(init_done), 32'd1);

      // First grant in the init_done cycle, m0 wins the first tie, then alternate
      step(1,0,10'h3FF,0, 1,0,10'h3FE,0, 1,0, 32'h0);
      step(1,0,10'h010,0, 1,0,10'h3FE,0, 0,1, 32'h0);
      step(1,0,10'h010,0, 1,0,10'h011,0, 1,0, 32'h0);
      step(1,0,10'h012,0, 1,0,10'h011,0, 0,1, 32'h0);
      step(1,0,10'h012,0, 1,0,10'h013,0, 1,0, 32'h0);
      step(0,0,10'h000,0, 1,0,10'h013,0, 0,1, 32'h0);

      // m0 write then read at address 5
      step(1,1,10'h005,32'hDEADBEEF, 0,0,0,0, 1,0, 32'h0);
      step(1,0,10'h005,0,            0,0,0,0, 1,0, 32'hDEADBEEF);

      // m1 write wins the tie, m0 read of the same word then sees it
      step(1,0,10'h200,0, 1,1,10'h200,32'h12345678, 0,1, 32'h0);
      step(1,0,10'h200,0, 0,0,0,0,                  1,0, 32'h12345678);
      step(0,0,0,0,       1,0,10'h200,0,            0,1, 32'h12345678);
      step(0,0,0,0, 0,0,0,0, 0,0, 32'h0);
      check("idle_addr_hold", 32'(mem_addr), 32'h200);
      step(0,0,0,0, 0,0,0,0, 0,0, 32'h0);
      check("m0_rdata_hold", m0_rdata, 32'h12345678);
      check("m1_rdata_hold", m1_rdata, 32'h12345678);

      // Reset at sweep count 300 aborts the sweep; it restarts from 0
      rst = 1'b0; #3;
      erv0 = 1'b0; erv1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      sweep(300);
      #2;
      check("sweep_count_300", 32'(mem_addr), 32'd300);
      rst = 1'b0; #1;
      check("midrst_mem_wr", 32'(mem_wr), 32'd0);
      check("midrst_init_done", 32'(init_done), 32'd0);
      check("midrst_m0_rdata", m0_rdata, 32'd0);
      check("midrst_m1_rdata", m1_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      sweep(1024);
      check("init_done_after_resweep", 32'(init_done), 32'd1);

      // Memory cleared again; tie priority back to m0 after reset
      step(1,0,10'h005,0, 1,0,10'h200,0, 1,0, 32'h0);
      step(0,0,0,0,       1,0,10'h200,0, 0,1, 32'h0);
      step(0,0,0,0, 0,0,0,0, 0,0, 32'h0);
      step(0,0,0,0, 0,0,0,0, 0,0, 32'h0);

      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_arbiter
